reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//   Producer side of hazard detection: tracks in-flight register writes between
//   ID issue and WB retire, and answers operand hazard queries from ID.
//   Sits beside the ID stage. Issue marks a destination pending; writeback clears it.
//   The hazard query covers any pipeline depth, not only the EXE/MEM stages.
// PARAMETERS
//   REG_AW    5   register address width (2**REG_AW architectural registers)
//   CNT_W     2   per-register in-flight counter width; max pending = 2**CNT_W-1
//   R0_ZERO   1   1: register 0 is hardwired; never marked pending, never hazards
//   STALL_W   16  width of stall-cycle statistics counter
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        reset, asynchronous, active-high
//   sb_clear       in   1        synchronous clear of all pending state
//   issue_valid    in   1        instruction leaves ID into EXE this cycle
//   issue_wb_en    in   1        issued instruction writes a register
//   issue_dst      in   REG_AW   issued destination register
//   wb_valid       in   1        WB stage writes register file this cycle
//   wb_dst         in   REG_AW   writeback destination register
//   Src1           in   REG_AW   ID operand 1 register
//   Src2           in   REG_AW   ID operand 2 register
//   is_two_source  in   1        1: Src2 is also read
//   Hazard_detected_signal out 1 combinational: ID must stall
//   busy           out  1        any register has a nonzero pending count
//   sb_overflow    out  1        sticky: issue to register already at max count
//   sb_underflow   out  1        sticky: writeback to register with count 0
//   stall_count    out  STALL_W  cycles with Hazard_detected_signal=1 (saturating)
// BEHAVIOUR
//   - State: cnt[r] (CNT_W bits) per register, plus the two sticky flags and stall_count.
//   - Reset: all cnt=0, busy=0, sb_overflow=0, sb_underflow=0, stall_count=0.
//     Reset mid-operation discards all pending state immediately (async).
//   - inc(r) = issue_valid & issue_wb_en & issue_dst==r; dec(r) = wb_valid & wb_dst==r.
//     When R0_ZERO=1, r=0 is excluded from both.
//   - Per clk: inc&!dec -> cnt+1; dec&!inc -> cnt-1; both or neither -> unchanged.
//   - inc at cnt==max: cnt held, sb_overflow<=1.
//   - dec&!inc at cnt==0: cnt held at 0, sb_underflow<=1. Sticky flags clear only
//     on rst or sb_clear.
//   - sb_clear: all cnt<=0, flags<=0, stall_count kept. Overrides same-cycle inc/dec.
//   - Hazard = pend(Src1) | (is_two_source & pend(Src2)).
//     pend(r) = cnt[r]!=0 (r=0 never pending when R0_ZERO=1).
//   - Query latency: 0 cycles from Src inputs. Issue/wb effects are visible the
//     cycle after the edge. Issue from ID must be gated by the stall (caller's
//     job); this block does not suppress issue_valid itself.
//   - busy = OR of all cnt!=0, from registered state.
//   - stall_count increments each clk while Hazard=1 and saturates at all-ones.
// CONFIGURATION
//   SCOREBOARD_WB_BYPASS_EN defined: pend(r) additionally requires
//     !(wb_valid & wb_dst==r & cnt[r]==1). The regfile writes first half-cycle, so
//     the last pending write retiring this cycle does not stall ID.
//   Not defined: a register is pending until the cycle after its retiring WB,
//     which costs one extra stall cycle per RAW.
// TESTING
//   1 rst mid-run with cnt[3]=2 -> all cnt 0, busy=0, flags 0, Hazard=0 immediately.
//   2 issue dst=5; next cycle Src1=5 -> Hazard=1. wb_dst=5 -> Hazard=1 that cycle
//     with no bypass, 0 with SCOREBOARD_WB_BYPASS_EN; Hazard=0 the cycle after.
//   3 issue dst=7 twice, wb 7 once -> cnt[7]=1, Hazard=1. Second wb -> Hazard=0.
//     Same-cycle issue 7 + wb 7 -> cnt unchanged.
//   4 issue dst=0, R0_ZERO=1 -> busy=0; Src1=0 -> Hazard=0.
//     is_two_source=0, Src2 pending -> Hazard=0.
//   5 four issues to reg 9 (CNT_W=2) -> cnt=3, sb_overflow=1.
//     wb to reg 4 with cnt 0 -> sb_underflow=1. sb_clear -> both 0.
//   6 Hazard held 70000 cycles, STALL_W=16 -> stall_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Producer side of register hazard detection. It sits beside the ID stage and
// keeps a small in-flight counter per architectural register. An instruction
// issued from ID with a register write marks its destination as pending. The
// matching writeback in WB retires it. The ID stage asks whether its source
// operands are still pending, and the answer is purely combinational, so it
// covers every pipeline depth between issue and retire.
//
// The caller must gate issue_valid with Hazard_detected_signal. This block
// only reports the hazard and never suppresses an issue itself.
//
// Parameters
//   REG_AW   register address width (2**REG_AW registers)
//   CNT_W    per-register in-flight counter width; max pending = 2**CNT_W-1
//   R0_ZERO  1: register 0 is hardwired, never pending, never hazards
//   STALL_W  width of the saturating stall-cycle counter
//
// Optional feature (compile-time macro): SCOREBOARD_WB_BYPASS_EN
//   When defined, a register whose last pending write retires in WB this cycle
//   is not reported pending. The register file writes in the first half-cycle,
//   so ID can read the fresh value. When undefined, the register stays pending
//   until the cycle after its retiring writeback. That costs one stall cycle
//   per RAW dependency.
//
// Ports
//   clk                     in   clock, rising edge
//   rst                     in   asynchronous active-high reset
//   sb_clear                in   synchronous clear of pending state and flags
//   issue_valid             in   instruction leaves ID into EXE this cycle
//   issue_wb_en             in   issued instruction writes a register
//   issue_dst   [REG_AW]    in   issued destination register
//   wb_valid                in   WB stage writes the register file this cycle
//   wb_dst      [REG_AW]    in   writeback destination register
//   Src1        [REG_AW]    in   ID operand 1 register
//   Src2        [REG_AW]    in   ID operand 2 register
//   is_two_source           in   Src2 is also read
//   Hazard_detected_signal  out  combinational: ID must stall
//   busy                    out  some register has a nonzero pending count
//   sb_overflow             out  sticky: issue to a register already at max
//   sb_underflow            out  sticky: writeback to a register with count 0
//   stall_count [STALL_W]   out  saturating count of hazard cycles
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 2,
    parameter bit R0_ZERO = 1'b1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sb_clear,
    input  logic               issue_valid,
    input  logic               issue_wb_en,
    input  logic [REG_AW-1:0]  issue_dst,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_dst,
    input  logic [REG_AW-1:0]  Src1,
    input  logic [REG_AW-1:0]  Src2,
    input  logic               is_two_source,
    output logic               Hazard_detected_signal,
    output logic               busy,
    output logic               sb_overflow,
    output logic               sb_underflow,
    output logic [STALL_W-1:0] stall_count
);

    localparam int                 NREG      = 1 << REG_AW;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    // One bit per register. Each bit is gathered from the per-register slices below.
    logic [NREG-1:0] pend_vec;   // register reads as pending to ID this cycle
    logic [NREG-1:0] nz_vec;     // registered count is nonzero
    logic [NREG-1:0] ovf_vec;    // this cycle's issue hits a full counter
    logic [NREG-1:0] unf_vec;    // this cycle's retire hits an empty counter

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        // Register 0 is hardwired when R0_ZERO is set. Its counter never moves,
        // so it can never be pending.
        localparam bit HARD_ZERO = R0_ZERO && (r == 0);

        logic [CNT_W-1:0] cnt;
        logic             inc;
        logic             dec;
        logic             wb_hit;

        assign wb_hit = wb_valid && (wb_dst == REG_AW'(r));
        assign inc    = !HARD_ZERO && issue_valid && issue_wb_en &&
                        (issue_dst == REG_AW'(r));
        assign dec    = !HARD_ZERO && wb_hit;

        // NOTE: the counters are ordinary flops rather than a RAM macro, so
        // resetting every entry is cheap. Reset also has to discard in-flight
        // state immediately.
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples values from before the edge.
            if (rst) begin
                cnt <= '0;
            end else if (sb_clear) begin
                cnt <= '0;
            end else if (inc && !dec && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end else if (dec && !inc && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            // An issue and a retire to the same register cancel out. A full
            // counter holds on issue, and an empty counter holds on retire.
        end

        assign nz_vec[r]  = (cnt != '0);
        assign ovf_vec[r] = inc && (cnt == CNT_MAX);
        assign unf_vec[r] = dec && !inc && (cnt == '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
        // The last outstanding write is retiring right now, and the register
        // file forwards it within the cycle.
        assign pend_vec[r] = nz_vec[r] && !(wb_hit && (cnt == CNT_W'(1)));
`else
        assign pend_vec[r] = nz_vec[r];
`endif
    end

    assign Hazard_detected_signal = pend_vec[Src1] | (is_two_source & pend_vec[Src2]);

    // busy looks only at registered counts, never at this cycle's inputs.
    assign busy = |nz_vec;

    // Sticky error flags. Only rst or sb_clear can drop them. sb_clear also
    // wins over an error detected in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_overflow  <= 1'b0;
            sb_underflow <= 1'b0;
        end else if (sb_clear) begin
            sb_overflow  <= 1'b0;
            sb_underflow <= 1'b0;
        end else begin
            if (|ovf_vec) sb_overflow  <= 1'b1;
            if (|unf_vec) sb_underflow <= 1'b1;
        end
    end

    // The stall statistics survive sb_clear. The counter stops at all-ones
    // instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (Hazard_detected_signal && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// Self-checking bench for reg_scoreboard (default parameters).
// Inputs are driven on the falling edge and outputs are sampled 1 time unit
// later, well away from the rising edge. The reference model tracks the plain
// integer in-flight count per register.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int REG_AW    = 5;
    localparam int CNT_W     = 2;
    localparam bit R0_ZERO   = 1'b1;
    localparam int STALL_W   = 16;
    localparam int NREG      = 1 << REG_AW;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int STALL_MAX = (1 << STALL_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               sb_clear;
    logic               issue_valid;
    logic               issue_wb_en;
    logic [REG_AW-1:0]  issue_dst;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_dst;
    logic [REG_AW-1:0]  Src1;
    logic [REG_AW-1:0]  Src2;
    logic               is_two_source;
    logic               Hazard_detected_signal;
    logic               busy;
    logic               sb_overflow;
    logic               sb_underflow;
    logic [STALL_W-1:0] stall_count;

    reg_scoreboard #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W),
        .R0_ZERO(R0_ZERO),
        .STALL_W(STALL_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .sb_clear              (sb_clear),
        .issue_valid           (issue_valid),
        .issue_wb_en           (issue_wb_en),
        .issue_dst             (issue_dst),
        .wb_valid              (wb_valid),
        .wb_dst                (wb_dst),
        .Src1                  (Src1),
        .Src2                  (Src2),
        .is_two_source         (is_two_source),
        .Hazard_detected_signal(Hazard_detected_signal),
        .busy                  (busy),
        .sb_overflow           (sb_overflow),
        .sb_underflow          (sb_underflow),
        .stall_count           (stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int m_cnt [NREG];
    bit m_ovf;
    bit m_unf;
    int m_stall;

    function automatic void m_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_stall = 0;
    endfunction

    function automatic bit m_pend(int r);
        if (R0_ZERO && r == 0) return 1'b0;
        if (m_cnt[r] == 0) return 1'b0;
        if (BYP && wb_valid && int'(wb_dst) == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_hazard();
        return m_pend(int'(Src1)) || (is_two_source && m_pend(int'(Src2)));
    endfunction

    function automatic bit m_busy();
        foreach (m_cnt[i]) if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Applies one clock edge of the rules to the model state.
    function automatic void m_update(bit hz);
        int  id;
        int  wd;
        bit  i;
        bit  d;
        id = int'(issue_dst);
        wd = int'(wb_dst);
        i  = issue_valid && issue_wb_en && !(R0_ZERO && id == 0);
        d  = wb_valid && !(R0_ZERO && wd == 0);
        if (hz && m_stall < STALL_MAX) m_stall++;
        if (sb_clear) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (i && d && id == wd) begin
            if (m_cnt[id] == CNT_MAX) m_ovf = 1'b1;
        end else begin
            if (i) begin
                if (m_cnt[id] == CNT_MAX) m_ovf = 1'b1;
                else m_cnt[id]++;
            end
            if (d) begin
                if (m_cnt[wd] == 0) m_unf = 1'b1;
                else m_cnt[wd]--;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".hazard"}, 32'(Hazard_detected_signal), 32'(m_hazard()));
        check({tag, ".busy"},   32'(busy),         32'(m_busy()));
        check({tag, ".ovf"},    32'(sb_overflow),  32'(m_ovf));
        check({tag, ".unf"},    32'(sb_underflow), 32'(m_unf));
        check({tag, ".stall"},  32'(stall_count),  32'(m_stall));
    endtask

    task automatic set_idle();
        sb_clear      = 1'b0;
        issue_valid   = 1'b0;
        issue_wb_en   = 1'b0;
        issue_dst     = '0;
        wb_valid      = 1'b0;
        wb_dst        = '0;
        Src1          = '0;
        Src2          = '0;
        is_two_source = 1'b0;
    endtask

    // Advance one cycle: capture model hazard with pre-edge inputs, clock,
    // update model, return on the falling edge.
    task automatic tick();
        bit hz;
        hz = m_hazard();
        @(posedge clk);
        m_update(hz);
        @(negedge clk);
    endtask

    task automatic drive(input bit iv, input int idst, input bit wv, input int wdst,
                         input int s1, input int s2, input bit two, input bit clr);
        issue_valid   = iv;
        issue_wb_en   = iv;
        issue_dst     = REG_AW'(idst);
        wb_valid      = wv;
        wb_dst        = REG_AW'(wdst);
        Src1          = REG_AW'(s1);
        Src2          = REG_AW'(s2);
        is_two_source = two;
        sb_clear      = clr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit iv;   int idst;
        bit wv;   int wdst;
        int s1;   int s2;   bit two;  bit clr;
        bit eh;   bit eb;
    } vec_t;

    function automatic vec_t mk(bit iv, int idst, bit wv, int wdst, int s1, int s2,
                                bit two, bit clr, bit eh, bit eb);
        vec_t v;
        v.iv = iv;  v.idst = idst; v.wv = wv; v.wdst = wdst;
        v.s1 = s1;  v.s2 = s2;     v.two = two; v.clr = clr;
        v.eh = eh;  v.eb = eb;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        // Expected hazard/busy are for the row's own cycle (state before its edge).
        //            iv dst wv wd s1 s2 two clr  hazard busy
        tbl[0]  = mk(1, 5,  0, 0,  5, 0, 0, 0,   0,    0);     // issue 5
        tbl[1]  = mk(0, 0,  0, 0,  5, 0, 0, 0,   1,    1);     // 5 pending
        tbl[2]  = mk(0, 0,  1, 5,  5, 0, 0, 0,   !BYP, 1);     // retire 5
        tbl[3]  = mk(0, 0,  0, 0,  5, 0, 0, 0,   0,    0);     // cleared
        tbl[4]  = mk(1, 7,  0, 0,  7, 0, 0, 0,   0,    0);     // issue 7
        tbl[5]  = mk(1, 7,  0, 0,  7, 0, 0, 0,   1,    1);     // issue 7 again
        tbl[6]  = mk(0, 0,  1, 7,  7, 0, 0, 0,   1,    1);     // wb 7 at cnt 2
        tbl[7]  = mk(0, 0,  0, 0,  7, 0, 0, 0,   1,    1);     // cnt 1
        tbl[8]  = mk(1, 7,  1, 7,  7, 0, 0, 0,   !BYP, 1);     // issue+wb 7
        tbl[9]  = mk(0, 0,  0, 0,  7, 0, 0, 0,   1,    1);     // still cnt 1
        tbl[10] = mk(0, 0,  1, 7,  7, 0, 0, 0,   !BYP, 1);     // last wb 7
        tbl[11] = mk(0, 0,  0, 0,  7, 0, 0, 0,   0,    0);
        tbl[12] = mk(1, 0,  0, 0,  0, 0, 0, 0,   0,    0);     // issue r0
        tbl[13] = mk(0, 0,  0, 0,  0, 0, 0, 0,   0,    0);     // r0 never busy
        tbl[14] = mk(1, 12, 0, 0,  0, 0, 0, 0,   0,    0);     // issue 12
        tbl[15] = mk(0, 0,  0, 0,  0, 12, 0, 0,  0,    1);     // Src2 ignored
        tbl[16] = mk(0, 0,  0, 0,  0, 12, 1, 0,  1,    1);     // Src2 read
        tbl[17] = mk(0, 0,  1, 12, 0, 12, 1, 0,  !BYP, 1);     // retire 12
        tbl[18] = mk(0, 0,  0, 0,  0, 12, 1, 0,  0,    0);
    end

    // ---------------- main sequence ----------------
    initial begin
        set_idle();
        m_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset.hazard", 32'(Hazard_detected_signal), 32'd0);
        check("reset.busy",   32'(busy),         32'd0);
        check("reset.ovf",    32'(sb_overflow),  32'd0);
        check("reset.unf",    32'(sb_underflow), 32'd0);
        check("reset.stall",  32'(stall_count),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].iv, tbl[k].idst, tbl[k].wv, tbl[k].wdst,
                  tbl[k].s1, tbl[k].s2, tbl[k].two, tbl[k].clr);
            #1;
            check($sformatf("vec%0d.hazard", k), 32'(Hazard_detected_signal), 32'(tbl[k].eh));
            check($sformatf("vec%0d.busy", k),   32'(busy), 32'(tbl[k].eb));
            check($sformatf("vec%0d.ovf", k),    32'(sb_overflow),  32'd0);
            check($sformatf("vec%0d.unf", k),    32'(sb_underflow), 32'd0);
            check($sformatf("vec%0d.stall", k),  32'(stall_count),  32'(m_stall));
            tick();
        end

        // Overflow: four issues to reg 9 saturate at 3
        for (int k = 0; k < 4; k++) begin
            drive(1, 9, 0, 0, 9, 0, 0, 0);
            #1;
            check($sformatf("ovf.pre%0d", k), 32'(sb_overflow), 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 9, 0, 0, 0);
        #1;
        check("ovf.set",    32'(sb_overflow), 32'd1);
        check("ovf.hazard", 32'(Hazard_detected_signal), 32'd1);
        // Three retires empty a counter held at 3 without underflow
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 9, 9, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 9, 0, 0, 0);
        #1;
        check("ovf.held3.hazard", 32'(Hazard_detected_signal), 32'd0);
        check("ovf.held3.busy",   32'(busy),         32'd0);
        check("ovf.held3.unf",    32'(sb_underflow), 32'd0);
        // Underflow on reg 4
        drive(0, 0, 1, 4, 4, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 4, 0, 0, 0);
        #1;
        check("unf.set",      32'(sb_underflow), 32'd1);
        check("unf.ovf_kept", 32'(sb_overflow),  32'd1);
        check("unf.busy",     32'(busy),         32'd0);
        // sb_clear beats a same-cycle issue and keeps stall_count
        drive(1, 9, 0, 0, 9, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 9, 0, 0, 0);
        #1;
        check("clr.ovf",   32'(sb_overflow),  32'd0);
        check("clr.unf",   32'(sb_underflow), 32'd0);
        check("clr.busy",  32'(busy),         32'd0);
        check("clr.stall", 32'(stall_count),  32'(m_stall));
        check_model("clr");

        // Mid-run async reset with cnt[3]=2 and a sticky flag set
        drive(1, 3, 0, 0, 3, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 1, 4, 3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 3, 0, 0, 0);
        #1;
        check("arst.pre.hazard", 32'(Hazard_detected_signal), 32'd1);
        check("arst.pre.busy",   32'(busy),         32'd1);
        check("arst.pre.unf",    32'(sb_underflow), 32'd1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("arst.hazard", 32'(Hazard_detected_signal), 32'd0);
        check("arst.busy",   32'(busy),         32'd0);
        check("arst.ovf",    32'(sb_overflow),  32'd0);
        check("arst.unf",    32'(sb_underflow), 32'd0);
        check("arst.stall",  32'(stall_count),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst.post.hazard", 32'(Hazard_detected_signal), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            issue_valid   = 1'($urandom_range(0, 1));
            issue_wb_en   = ($urandom_range(0, 3) != 0);
            issue_dst     = REG_AW'($urandom_range(0, 7));
            wb_valid      = 1'($urandom_range(0, 1));
            wb_dst        = REG_AW'($urandom_range(0, 7));
            Src1          = REG_AW'($urandom_range(0, 7));
            Src2          = REG_AW'($urandom_range(0, 7));
            is_two_source = 1'($urandom_range(0, 1));
            sb_clear      = ($urandom_range(0, 39) == 0);
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        // stall_count saturation: hold a hazard for 70000 cycles
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        for (int c = 0; c < 70000; c++) tick();
        #1;
        check("sat.hazard", 32'(Hazard_detected_signal), 32'd1);
        check("sat.value",  32'(stall_count), 32'hFFFF);
        check("sat.model",  32'(stall_count), 32'(m_stall));
        tick();
        #1;
        check("sat.nowrap", 32'(stall_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
